// File: rtl/vga_image_window.sv
// Image-window renderer: maps a double-buffered IMG_W x IMG_H display RAM onto the VGA raster.
// Optional 2x2 pixel scaling is enabled by defining VGA_IMG_SCALE2X_EN.
module vga_image_window #(
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          X0        = 0,
    parameter int          Y0        = 0,
    parameter int          V_ACTIVE  = 480,
    parameter bit          MONO      = 1'b1,
    parameter logic [2:0]  FG_COLOR  = 3'b111,
    parameter logic [2:0]  BG_COLOR  = 3'b010,
    parameter logic        SYNC_IDLE = 1'b1,
    parameter int          ADDR_W    = $clog2(IMG_W * IMG_H) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        counter_x,
    input  logic [9:0]        counter_y,
    input  logic              in_display_area,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [2:0]        mem_q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        pixel,
    output logic              hsync_out,
    output logic              vsync_out,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              buf_sel
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
`ifdef VGA_IMG_SCALE2X_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif
    localparam logic [11:0] W_EFF = 12'(IMG_W << SC);
    localparam logic [11:0] H_EFF = 12'(IMG_H << SC);

    typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

    logic [11:0]       dx, dy;
    logic              in_img_c;
    logic [XW-1:0]     ix_c;
    logic [YW-1:0]     iy_c;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        disp_q, img_q;
    logic [2:0]        hs_q, vs_q;
    logic [2:0]        pixel_q, pixel_d;
    swap_state_t       state_q, state_d;
    logic              buf_sel_q, buf_sel_d;
    logic              swap_ack_q, swap_ack_d;
    logic              swap_pt;

    // Left/above the origin the subtraction wraps to a huge value, so one
    // unsigned compare covers both window edges on each axis.
    assign dx       = {2'b00, counter_x} - 12'(X0);
    assign dy       = {2'b00, counter_y} - 12'(Y0);
    assign in_img_c = in_display_area && (dx < W_EFF) && (dy < H_EFF);

`ifdef VGA_IMG_SCALE2X_EN
    assign ix_c = dx[XW:1];
    assign iy_c = dy[YW:1];
`else
    assign ix_c = dx[XW-1:0];
    assign iy_c = dy[YW-1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            disp_q    <= '0;
            img_q     <= '0;
            hs_q      <= {3{SYNC_IDLE}};
            vs_q      <= {3{SYNC_IDLE}};
            pixel_q   <= 3'b000;
        end else begin
            if (in_img_c)
                rd_addr_q <= {buf_sel_q, iy_c, ix_c};
            disp_q  <= {disp_q[0], in_display_area};
            img_q   <= {img_q[0], in_img_c};
            hs_q    <= {hs_q[1:0], hsync_in};
            vs_q    <= {vs_q[1:0], vsync_in};
            pixel_q <= pixel_d;
        end
    end

    // Stage-2 flags line up with mem_q, which the RAM returns one cycle after rd_addr.
    always_comb begin
        pixel_d = 3'b000;
        if (!disp_q[1])
            pixel_d = 3'b000;
        else if (!img_q[1])
            pixel_d = BG_COLOR;
        else if (MONO)
            pixel_d = mem_q[0] ? FG_COLOR : 3'b000;
        else
            pixel_d = mem_q;
    end

    assign swap_pt = (counter_y == 10'(V_ACTIVE)) && (counter_x == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            buf_sel_q  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_sel_q  <= buf_sel_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_sel_d  = buf_sel_q;
        swap_ack_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req && swap_pt) begin
                    buf_sel_d  = ~buf_sel_q;
                    swap_ack_d = 1'b1;
                end else if (swap_req) begin
                    state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (swap_pt) begin
                    buf_sel_d  = ~buf_sel_q;
                    swap_ack_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_addr   = rd_addr_q;
    assign pixel     = pixel_q;
    assign hsync_out = hs_q[2];
    assign vsync_out = vs_q[2];
    assign swap_ack  = swap_ack_q;
    assign buf_sel   = buf_sel_q;

endmodule

// File: tb/tb_vga_image_window.sv
// Directed bench for vga_image_window: default, offset-origin and raw-RGB instances
// share one raster stimulus; the default instance reads a behavioural synchronous RAM.
module tb_vga_image_window;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] counter_x, counter_y;
    logic       in_display_area, hsync_in, vsync_in, swap_req;

    logic [2:0]  mem [0:8191];
    logic [2:0]  mem_q;
    logic [2:0]  mem_q_off, mem_q_rgb;

    logic [12:0] rd_addr, rd_addr_off, rd_addr_rgb;
    logic [2:0]  pixel, pixel_off, pixel_rgb;
    logic        hsync_out, vsync_out, swap_ack, buf_sel;
    logic        hs_off, vs_off, ack_off, bsel_off;
    logic        hs_rgb, vs_rgb, ack_rgb, bsel_rgb;

    int tests = 0;
    int fails = 0;

    always #20 clk = ~clk;

    always @(posedge clk) mem_q <= mem[rd_addr];

    vga_image_window dut (
        .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
        .in_display_area(in_display_area), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_q(mem_q), .rd_addr(rd_addr), .pixel(pixel), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel)
    );

    vga_image_window #(.X0(100), .Y0(50)) dut_off (
        .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
        .in_display_area(in_display_area), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_q(mem_q_off), .rd_addr(rd_addr_off), .pixel(pixel_off), .hsync_out(hs_off),
        .vsync_out(vs_off), .swap_req(1'b0), .swap_ack(ack_off), .buf_sel(bsel_off)
    );

    vga_image_window #(.MONO(1'b0)) dut_rgb (
        .clk(clk), .reset(reset), .counter_x(counter_x), .counter_y(counter_y),
        .in_display_area(in_display_area), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_q(mem_q_rgb), .rd_addr(rd_addr_rgb), .pixel(pixel_rgb), .hsync_out(hs_rgb),
        .vsync_out(vs_rgb), .swap_req(1'b0), .swap_ack(ack_rgb), .buf_sel(bsel_rgb)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one raster position with 640x480 visible area and standard sync pulses.
    task automatic step(input int x, input int y);
        counter_x       = 10'(x);
        counter_y       = 10'(y);
        in_display_area = (x < 640) && (y < 480);
        hsync_in        = !(x >= 656 && x < 752);
        vsync_in        = !(y == 490 || y == 491);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] a;
        for (int i = 0; i < 8192; i++) begin
            a = 13'(i);
            mem[i] = a[12] ? 3'b001 : {2'b00, ~(a[0] ^ a[6])};
        end
        mem_q_off = 3'b000;
        mem_q_rgb = 3'b101;
        swap_req  = 1'b0;
        reset     = 1'b1;
        counter_x = '0;
        counter_y = '0;
        in_display_area = 1'b0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", 16'(pixel), 16'h0);
        chk("rst_hsync", 16'(hsync_out), 16'h1);
        chk("rst_vsync", 16'(vsync_out), 16'h1);
        chk("rst_rd_addr", 16'(rd_addr), 16'h0);
        chk("rst_buf_sel", 16'(buf_sel), 16'h0);
        chk("rst_swap_ack", 16'(swap_ack), 16'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef VGA_IMG_SCALE2X_EN
        step(1, 1);   chk("s2_addr_1_1", 16'(rd_addr), 16'd0);
        step(2, 0);   chk("s2_addr_2_0", 16'(rd_addr), 16'd1);
        step(128, 0); chk("s2_addr_hold", 16'(rd_addr), 16'd1);
        step(127, 0); chk("s2_addr_127", 16'(rd_addr), 16'd63);
        step(0, 500); chk("s2_pix_128_0", 16'(pixel), 16'h2);
`else
        step(0, 0);    chk("addr_0_0", 16'(rd_addr), 16'd0);
        step(1, 0);    chk("addr_1_0", 16'(rd_addr), 16'd1);
        step(64, 10);  chk("addr_hold", 16'(rd_addr), 16'd1);
                       chk("pix_0_0", 16'(pixel), 16'h7);
                       chk("rgb_pix_0_0", 16'(pixel_rgb), 16'h5);
        step(2, 0);    chk("addr_2_0", 16'(rd_addr), 16'd2);
                       chk("pix_1_0", 16'(pixel), 16'h0);
        step(700, 10); chk("pix_64_10_bg", 16'(pixel), 16'h2);
                       chk("rgb_pix_bg", 16'(pixel_rgb), 16'h2);
        step(99, 50);  chk("pix_2_0", 16'(pixel), 16'h7);
        step(100, 50); chk("off_addr_origin", 16'(rd_addr_off), 16'd0);
                       chk("pix_blank", 16'(pixel), 16'h0);
                       chk("hsync_delay_lo", 16'(hsync_out), 16'h0);
                       chk("rgb_hsync_lo", 16'(hs_rgb), 16'h0);
        step(163, 113); chk("off_addr_last", 16'(rd_addr_off), 16'd4095);
                       chk("hsync_delay_hi", 16'(hsync_out), 16'h1);
                       chk("off_pix_99_50", 16'(pixel_off), 16'h2);
        step(164, 113); chk("off_addr_hold", 16'(rd_addr_off), 16'd4095);
                       chk("off_pix_origin", 16'(pixel_off), 16'h0);
                       chk("pix_100_50_bg", 16'(pixel), 16'h2);
        step(163, 114); chk("off_pix_last", 16'(pixel_off), 16'h0);
        step(0, 500);  chk("off_pix_right_edge", 16'(pixel_off), 16'h2);
        step(0, 490);  chk("off_pix_bottom_edge", 16'(pixel_off), 16'h2);
        step(1, 490);
        step(2, 490);  chk("vsync_delay_lo", 16'(vsync_out), 16'h0);
`endif

        swap_req = 1'b1; step(0, 200); swap_req = 1'b0;
        chk("swap_wait_sel", 16'(buf_sel), 16'h0);
        chk("swap_wait_ack", 16'(swap_ack), 16'h0);
        step(639, 479); chk("swap_pre_sel", 16'(buf_sel), 16'h0);
        step(0, 480);   chk("swap_sel", 16'(buf_sel), 16'h1);
                        chk("swap_ack", 16'(swap_ack), 16'h1);
        step(1, 480);   chk("swap_ack_pulse", 16'(swap_ack), 16'h0);
        step(0, 0);     chk("swap_addr_msb", 16'(rd_addr), 16'h1000);

        for (int y = 100; y <= 300; y += 100) begin
            swap_req = 1'b1; step(0, y); swap_req = 1'b0;
            step(5, y);
        end
        step(0, 480);   chk("multi_sel", 16'(buf_sel), 16'h0);
                        chk("multi_ack", 16'(swap_ack), 16'h1);
        step(1, 480);
        step(0, 480);   chk("multi_once_sel", 16'(buf_sel), 16'h0);
                        chk("multi_once_ack", 16'(swap_ack), 16'h0);

        swap_req = 1'b1; step(0, 480); swap_req = 1'b0;
        chk("immed_sel", 16'(buf_sel), 16'h1);
        chk("immed_ack", 16'(swap_ack), 16'h1);
        step(1, 480);
        step(0, 480);   chk("immed_no_pend", 16'(buf_sel), 16'h1);

        swap_req = 1'b1; step(0, 100);
        step(0, 480);   chk("held_sel_1", 16'(buf_sel), 16'h0);
        step(1, 480);   chk("held_ack_pulse", 16'(swap_ack), 16'h0);
        step(0, 480);   chk("held_sel_2", 16'(buf_sel), 16'h1);
        swap_req = 1'b0;
        step(2, 480);

        swap_req = 1'b1; step(0, 200); swap_req = 1'b0;
        step(0, 0);     chk("pre_rst_addr", 16'(rd_addr), 16'h1000);
        #5 reset = 1'b1;
        #2;
        chk("arst_rd_addr", 16'(rd_addr), 16'h0);
        chk("arst_buf_sel", 16'(buf_sel), 16'h0);
        chk("arst_pixel", 16'(pixel), 16'h0);
        chk("arst_hsync", 16'(hsync_out), 16'h1);
        chk("arst_vsync", 16'(vsync_out), 16'h1);
        chk("arst_ack", 16'(swap_ack), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 480);   chk("rst_drop_sel", 16'(buf_sel), 16'h0);
                        chk("rst_drop_ack", 16'(swap_ack), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
